// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : i2c_txn_arbiter
// Description : Two-port round-robin arbiter that expands register read/write
//               requests into START/address/data/STOP commands for an I2C engine.
// Revision    : 1.0 - initial release
// =============================================================================
module i2c_txn_arbiter #(
  parameter int TIMEOUT_CYC = 200000,
  parameter int TO_W        = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [6:0]  saddr0,
  input  logic [6:0]  saddr1,
  input  logic [7:0]  raddr0,
  input  logic [7:0]  raddr1,
  input  logic        nb0,
  input  logic        nb1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [1:0]  err0,
  output logic [1:0]  err1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [2:0]  cmd,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic        eng_done,
  input  logic        eng_ack,
  input  logic [7:0]  eng_rx,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT       = 3'd3,
    ST_STEP       = 3'd4,
    ST_STOP_ABORT = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    SQ_START0  = 4'd0,
    SQ_SADDR_W = 4'd1,
    SQ_RADDR   = 4'd2,
    SQ_WHI     = 4'd3,
    SQ_WLO     = 4'd4,
    SQ_START1  = 4'd5,
    SQ_SADDR_R = 4'd6,
    SQ_RACK    = 4'd7,
    SQ_RNACK   = 4'd8,
    SQ_STOP    = 4'd9
  } step_t;

  localparam logic [2:0] c_cmd_start = 3'd0;
  localparam logic [2:0] c_cmd_write = 3'd1;
  localparam logic [2:0] c_cmd_rack  = 3'd2;
  localparam logic [2:0] c_cmd_rnack = 3'd3;
  localparam logic [2:0] c_cmd_stop  = 3'd4;

  localparam logic [1:0] c_err_ok   = 2'b00;
  localparam logic [1:0] c_err_nack = 2'b01;
  localparam logic [1:0] c_err_to   = 2'b10;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

  state_t         r_state, w_state_next;
  step_t          r_step, w_step_next, w_step_seq;
  logic [1:0]     r_err, w_err_next;
  logic [TO_W-1:0] r_cnt;
  logic           r_owner;
  logic           r_last_port;
  logic [1:0]     r_grant;
  logic           r_rw;
  logic [6:0]     r_saddr;
  logic [7:0]     r_raddr;
  logic           r_nb;
  logic [15:0]    r_wdata;
  logic           r_ack;
  logic [15:0]    r_rbuf;
  logic [1:0]     r_err0, r_err1;
  logic [15:0]    r_rdata0, r_rdata1;
  logic           w_winner;
  logic [2:0]     w_cmd;
  logic [7:0]     w_cmd_byte;
  logic           w_is_write;

  // Both requesting: the port that did not own the last transaction wins.
  assign w_winner = (req0 && req1) ? ~r_last_port : req1;

  always_comb begin
    w_cmd      = c_cmd_stop;
    w_cmd_byte = 8'h00;
    case (r_step)
      SQ_START0, SQ_START1: w_cmd = c_cmd_start;
      SQ_SADDR_W: begin w_cmd = c_cmd_write; w_cmd_byte = {r_saddr, 1'b0}; end
      SQ_RADDR:   begin w_cmd = c_cmd_write; w_cmd_byte = r_raddr;         end
      SQ_WHI:     begin w_cmd = c_cmd_write; w_cmd_byte = r_wdata[15:8];   end
      SQ_WLO:     begin w_cmd = c_cmd_write; w_cmd_byte = r_wdata[7:0];    end
      SQ_SADDR_R: begin w_cmd = c_cmd_write; w_cmd_byte = {r_saddr, 1'b1}; end
      SQ_RACK:    w_cmd = c_cmd_rack;
      SQ_RNACK:   w_cmd = c_cmd_rnack;
      default:    w_cmd = c_cmd_stop;
    endcase
  end

  assign w_is_write = (w_cmd == c_cmd_write);

  always_comb begin
    w_step_seq = SQ_STOP;
    case (r_step)
      SQ_START0:  w_step_seq = SQ_SADDR_W;
      SQ_SADDR_W: w_step_seq = SQ_RADDR;
      SQ_RADDR:   w_step_seq = r_rw ? SQ_START1 : (r_nb ? SQ_WHI : SQ_WLO);
      SQ_WHI:     w_step_seq = SQ_WLO;
      SQ_WLO:     w_step_seq = SQ_STOP;
      SQ_START1:  w_step_seq = SQ_SADDR_R;
      SQ_SADDR_R: w_step_seq = r_nb ? SQ_RACK : SQ_RNACK;
      SQ_RACK:    w_step_seq = SQ_RNACK;
      SQ_RNACK:   w_step_seq = SQ_STOP;
      default:    w_step_seq = SQ_STOP;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: if (req0 || req1) w_state_next = ST_ARB;
      ST_ARB: begin
        if (req0 || req1) begin
          w_state_next = ST_ISSUE;
          w_step_next  = SQ_START0;
          w_err_next   = c_err_ok;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ISSUE: if (cmd_ready) w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          w_state_next = ST_STEP;
        end else if (r_cnt == c_to_last) begin
          // A stalled STOP ends the transaction outright; keep the first error.
          if (r_err == c_err_ok) w_err_next = c_err_to;
          w_state_next = (r_step == SQ_STOP) ? ST_DONE : ST_STOP_ABORT;
        end
      end
      ST_STEP: begin
        if (r_step == SQ_STOP) begin
          w_state_next = ST_DONE;
        end else if (w_is_write && !r_ack) begin
          w_err_next   = c_err_nack;
          w_state_next = ST_STOP_ABORT;
        end else begin
          w_step_next  = w_step_seq;
          w_state_next = ST_ISSUE;
        end
      end
      ST_STOP_ABORT: begin
        w_step_next  = SQ_STOP;
        w_state_next = ST_ISSUE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= SQ_START0;
      r_err       <= c_err_ok;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_last_port <= 1'b1;
      r_grant     <= 2'b00;
      r_rw        <= 1'b0;
      r_saddr     <= 7'h00;
      r_raddr     <= 8'h00;
      r_nb        <= 1'b0;
      r_wdata     <= 16'h0000;
      r_ack       <= 1'b0;
      r_rbuf      <= 16'h0000;
      r_err0      <= c_err_ok;
      r_err1      <= c_err_ok;
      r_rdata0    <= 16'h0000;
      r_rdata1    <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_err   <= w_err_next;

      if (r_state == ST_ARB && (req0 || req1)) begin
        r_owner <= w_winner;
        r_grant <= w_winner ? 2'b10 : 2'b01;
        r_rw    <= w_winner ? rw1    : rw0;
        r_saddr <= w_winner ? saddr1 : saddr0;
        r_raddr <= w_winner ? raddr1 : raddr0;
        r_nb    <= w_winner ? nb1    : nb0;
        r_wdata <= w_winner ? wdata1 : wdata0;
        r_rbuf  <= 16'h0000;
      end

      if (r_state == ST_ISSUE && cmd_ready) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_WAIT && eng_done) begin
        r_ack <= eng_ack;
        if (r_step == SQ_RACK)  r_rbuf[15:8] <= eng_rx;
        if (r_step == SQ_RNACK) r_rbuf[7:0]  <= eng_rx;
      end

      if (w_state_next == ST_DONE && r_state != ST_DONE) begin
        if (r_owner) begin
          r_err1   <= w_err_next;
          r_rdata1 <= r_rbuf;
        end else begin
          r_err0   <= w_err_next;
          r_rdata0 <= r_rbuf;
        end
      end

      if (r_state == ST_DONE) begin
        r_grant     <= 2'b00;
        r_last_port <= r_owner;
      end
    end
  end

  assign cmd_valid = (r_state == ST_ISSUE);
  assign cmd       = cmd_valid ? w_cmd : 3'd0;
  assign cmd_byte  = cmd_valid ? w_cmd_byte : 8'h00;
  assign done0     = (r_state == ST_DONE) && !r_owner;
  assign done1     = (r_state == ST_DONE) && r_owner;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign grant     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Directed bench for i2c_txn_arbiter with a behavioural I2C engine.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, rw0, rw1, nb0, nb1;
  logic [6:0]  saddr0, saddr1;
  logic [7:0]  raddr0, raddr1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1;
  logic [1:0]  err0, err1;
  logic [15:0] rdata0, rdata1;
  logic [2:0]  cmd;
  logic [7:0]  cmd_byte;
  logic        cmd_valid, cmd_ready, eng_done, eng_ack;
  logic [7:0]  eng_rx;
  logic [1:0]  grant;

  i2c_txn_arbiter #(.TIMEOUT_CYC(50), .TO_W(18)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .saddr0(saddr0), .saddr1(saddr1), .raddr0(raddr0), .raddr1(raddr1),
    .nb0(nb0), .nb1(nb1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .cmd(cmd), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rx(eng_rx), .grant(grant)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [10:0] log_q [$];
  logic [10:0] exp_q [$];
  logic [7:0]  rx_q  [$];
  logic [1:0]  grant_q [$];
  logic [1:0]  prev_grant = 2'b00;
  int          eng_idx = 0, nack_idx = -1, hang_idx = -1;
  int          hang_cyc = 0, stop_cyc = 0;
  int          d0_cnt = 0, d1_cnt = 0;
  logic [1:0]  got_err;
  logic [15:0] got_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
    prev_grant = grant;
    if (done0) d0_cnt++;
    if (done1) d1_cnt++;
  end

  // Engine model: logs each accepted command as {cmd, byte}, answers after a short latency.
  initial begin
    logic [2:0] c;
    logic       ack, hang;
    cmd_ready = 1'b1; eng_done = 1'b0; eng_ack = 1'b0; eng_rx = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (cmd_valid && cmd_ready) begin
        c = cmd;
        log_q.push_back({cmd, (cmd == 3'd1) ? cmd_byte : 8'h00});
        ack  = (eng_idx != nack_idx);
        hang = (eng_idx == hang_idx);
        if (hang) hang_cyc = cyc;
        if (c == 3'd4) stop_cyc = cyc;
        eng_idx++;
        @(negedge clk);
        if (!hang) begin
          cmd_ready = 1'b0;
          @(negedge clk);
          eng_done = 1'b1;
          eng_ack  = ack;
          eng_rx   = ((c == 3'd2 || c == 3'd3) && rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
          @(negedge clk);
          eng_done  = 1'b0;
          eng_ack   = 1'b0;
          cmd_ready = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), {21'd0, log_q[i]}, {21'd0, exp_q[i]});
  endtask

  task automatic clear_eng();
    log_q.delete(); exp_q.delete(); rx_q.delete(); grant_q.delete();
    eng_idx = 0; nack_idx = -1; hang_idx = -1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_txn(input int port, input logic rw, input logic [6:0] sa,
                         input logic [7:0] ra, input logic nb, input logic [15:0] wd);
    int   n;
    logic seen;
    if (port == 0) begin rw0 = rw; saddr0 = sa; raddr0 = ra; nb0 = nb; wdata0 = wd; req0 = 1'b1; end
    else           begin rw1 = rw; saddr1 = sa; raddr1 = ra; nb1 = nb; wdata1 = wd; req1 = 1'b1; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      seen = (port == 0) ? done0 : done1;
    end
    check($sformatf("done%0d_seen", port), {31'd0, seen}, 32'd1);
    got_err   = (port == 0) ? err0 : err1;
    got_rdata = (port == 0) ? rdata0 : rdata1;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic wait_any_done(output int port);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    port = 0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      seen = done0 || done1;
    end
    check("any_done_seen", {31'd0, seen}, 32'd1);
    port = done1 ? 1 : 0;
  endtask

  initial begin
    int p;
    int n;
    rw0 = 0; rw1 = 0; nb0 = 0; nb1 = 0; saddr0 = 0; saddr1 = 0;
    raddr0 = 0; raddr1 = 0; wdata0 = 0; wdata1 = 0;
    apply_reset();

    check("rst_ctrl", {grant, cmd_valid, cmd, cmd_byte, done0, done1}, 32'd0);
    check("rst_err", {err0, err1}, 32'd0);
    check("rst_rdata", {rdata0, rdata1}, 32'd0);

    // Single-byte write from port 0
    clear_eng();
    run_txn(0, 1'b0, 7'h4B, 8'h03, 1'b0, 16'h0080);
    exp_q = '{11'h000, 11'h196, 11'h103, 11'h180, 11'h400};
    check_log("wr0");
    check("wr0_err", got_err, 2'b00);
    check("wr0_grant", grant_q.size() > 0 ? grant_q[0] : 2'b00, 2'b01);
    @(negedge clk);
    check("wr0_grant_idle", grant, 2'b00);

    // Two-byte read from port 1
    clear_eng();
    rx_q = '{8'h0C, 8'h90};
    run_txn(1, 1'b1, 7'h4B, 8'h00, 1'b1, 16'h0000);
    exp_q = '{11'h000, 11'h196, 11'h100, 11'h000, 11'h197, 11'h200, 11'h300, 11'h400};
    check_log("rd1");
    check("rd1_rdata", got_rdata, 16'h0C90);
    check("rd1_err", got_err, 2'b00);
    repeat (2) @(negedge clk);

    // Simultaneous requests from reset: expect 0, then 1 by round robin, then 0
    apply_reset();
    clear_eng();
    d0_cnt = 0; d1_cnt = 0;
    rw0 = 0; saddr0 = 7'h4B; raddr0 = 8'h01; nb0 = 0; wdata0 = 16'h0011;
    rw1 = 0; saddr1 = 7'h4B; raddr1 = 8'h02; nb1 = 0; wdata1 = 16'h0022;
    req0 = 1'b1; req1 = 1'b1;
    wait_any_done(p);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    repeat (2) @(negedge clk);
    if (p == 0) req0 = 1'b1; else req1 = 1'b1;
    wait_any_done(p);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    wait_any_done(p);
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) @(negedge clk);
    check("rr_count", grant_q.size(), 3);
    check("rr_g0", grant_q.size() > 0 ? grant_q[0] : 2'b00, 2'b01);
    check("rr_g1", grant_q.size() > 1 ? grant_q[1] : 2'b00, 2'b10);
    check("rr_g2", grant_q.size() > 2 ? grant_q[2] : 2'b00, 2'b01);
    check("rr_done0_cnt", d0_cnt, 2);
    check("rr_done1_cnt", d1_cnt, 1);

    // NACK on the address byte: STOP follows immediately, no data bytes
    clear_eng();
    nack_idx = 1;
    run_txn(0, 1'b0, 7'h4B, 8'h03, 1'b1, 16'h1234);
    exp_q = '{11'h000, 11'h196, 11'h400};
    check_log("nack");
    check("nack_err", got_err, 2'b01);
    repeat (2) @(negedge clk);

    // Engine hangs on WR raddr: 1 cycle to accept + 50 WAIT cycles + 1 abort cycle to STOP
    clear_eng();
    hang_idx = 2;
    run_txn(0, 1'b0, 7'h4B, 8'h03, 1'b0, 16'h0080);
    exp_q = '{11'h000, 11'h196, 11'h103, 11'h400};
    check_log("tmo");
    check("tmo_err", got_err, 2'b10);
    check("tmo_delay", stop_cyc - hang_cyc, 52);
    repeat (2) @(negedge clk);

    // Reset while waiting on the engine mid-read, then a fresh read
    clear_eng();
    rw1 = 1'b1; saddr1 = 7'h4B; raddr1 = 8'h00; nb1 = 1'b1; req1 = 1'b1;
    n = 0;
    while (log_q.size() < 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("mid_reached", {31'd0, log_q.size() >= 2}, 32'd1);
    @(negedge clk);
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk);
    check("mid_rst_ctrl", {grant, cmd_valid, cmd, cmd_byte, done0, done1, err0, err1}, 32'd0);
    check("mid_rst_rdata", {rdata0, rdata1}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    clear_eng();
    rx_q = '{8'h55};
    run_txn(1, 1'b1, 7'h4B, 8'h05, 1'b0, 16'h0000);
    exp_q = '{11'h000, 11'h196, 11'h105, 11'h000, 11'h197, 11'h300, 11'h400};
    check_log("post_rst");
    check("post_rst_rdata", got_rdata, 16'h0055);
    check("post_rst_err", got_err, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Transaction-level sequencer and arbiter in front of the byte-level I2C SERDES engine that drives the ADT7420 bus.
- Shares the engine between two requesters: port 0 (PC register-access path from the sensor controller) and port 1 (autonomous temperature poller).
- Expands each register read/write request into the START / address / register / data / STOP command sequence.
- Reports read data, completion and NACK/timeout errors back to the granted requester.

Parameters:
- TIMEOUT_CYC, 200000: max clk cycles to wait for one engine command to complete before abort.
- TO_W, 18: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock (differential-buffered board oscillator)
- rst  in  1  synchronous active-high reset
- req0 / req1  in  1  transaction request; held high until matching done pulse
- rw0 / rw1  in  1  1 = read, 0 = write
- saddr0 / saddr1  in  7  7-bit slave address
- raddr0 / raddr1  in  8  register address
- nb0 / nb1  in  1  0 = 1 data byte, 1 = 2 data bytes
- wdata0 / wdata1  in  16  write data; MSB byte sent first; 1-byte write uses [7:0]
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  2  valid with done: 00 ok, 01 NACK, 10 timeout
- rdata0 / rdata1  out  16  read data, valid with done; 1-byte read returns {8'h00, byte}
- cmd  out  3  engine command: 0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP
- cmd_byte  out  8  byte for WRITE
- cmd_valid  out  1  command strobe
- cmd_ready  in  1  engine idle; command accepted when cmd_valid && cmd_ready
- eng_done  in  1  one-cycle pulse when the accepted command finishes
- eng_ack  in  1  valid with eng_done on WRITE; 1 = slave ACKed
- eng_rx  in  8  valid with eng_done on READ_*
- grant  out  2  one-hot owner; 00 when idle

Behaviour:
Reset:
- All outputs 0.
- FSM to IDLE; round-robin pointer favours port 0.
- No STOP is issued on reset mid-transaction (the engine is reset separately).

States and transitions:
- IDLE → ARB when any req is high.
- ARB (1 cycle): latch the winner's request fields and set grant.
  - Only one req: that port wins.
  - Both reqs: the port not served last wins; pointer flips after each completed transaction.
- ISSUE: drive cmd/cmd_byte with cmd_valid high until accepted, then → WAIT.
- WAIT: hold cmd_valid low and count cycles.
  - On eng_done → STEP.
  - If counter reaches TIMEOUT_CYC → STOP_ABORT with err=10.
- STEP: advance the step index or branch.
  - WRITE with eng_ack=0 → STOP_ABORT with err=01.
- STOP_ABORT: issue STOP (normal ISSUE/WAIT path, with its own timeout); then DONE.
  - A timeout while issuing this STOP goes straight to DONE, err stays 10.
- DONE (1 cycle): pulse done and err (and rdata) on the granted port; clear grant; → IDLE.

Write sequence:
- START, WRITE {saddr,0}, WRITE raddr, WRITE wdata[15:8] (only if nb=1), WRITE wdata[7:0], STOP.

Read sequence:
- START, WRITE {saddr,0}, WRITE raddr, START (repeated), WRITE {saddr,1}.
- Then READ_ACK (only if nb=1; byte → rdata[15:8]), READ_NACK (byte → rdata[7:0]), STOP.

Rules:
- Latched fields are immune to requester changes after ARB.
- Deasserting req mid-transaction is ignored; the transaction completes and done still pulses.
- Next arbitration is no earlier than the cycle after DONE, so the same port needs ≥2 idle cycles between transactions.
- rdata/err hold their value until the next done on that port.
- eng_done arriving while not in WAIT is ignored.
- Timeout counter clears on every accept.

Test Plan:
- Write, port 0: saddr=0x4B, raddr=0x03, nb=0, wdata=0x0080, engine always ACKs → commands START, WR 0x96, WR 0x03, WR 0x80, STOP; done0 with err0=00; grant returns to 00.
- Read, port 1: raddr=0x00, nb=1, engine returns 0x0C then 0x90 → START, WR 0x96, WR 0x00, START, WR 0x97, READ_ACK, READ_NACK, STOP; rdata1=0x0C90, err1=00.
- Simultaneous req0/req1 from reset, repeated 3 times → grant order 0,1,0; each done pulses exactly once.
- NACK: eng_ack=0 on the address byte of a port-0 write → next command is STOP, then done0 with err0=01; no data bytes are issued.
- Timeout: TIMEOUT_CYC=50, engine never pulses eng_done after accepting WR raddr → STOP issued after 50 cycles; done with err=10.
- Reset asserted mid-read (in WAIT) → next cycle all outputs 0 and grant=00; a fresh req1 is then served correctly.
